// File: rtl/sat_formula_sequencer_if.sv
// Literal stream carrying a CNF formula into sat_formula_sequencer.
// The master drives the literals and the slave (the sequencer) drives lit_ready.
interface sat_formula_sequencer_if #(
    parameter int VAR_W = 5
);
    logic             lit_valid;
    logic             lit_ready;
    logic [VAR_W-1:0] lit_var;
    logic             lit_neg;
    logic             lit_eoc;
    logic             lit_eof;

    modport master (
        output lit_valid, lit_var, lit_neg, lit_eoc, lit_eof,
        input  lit_ready
    );

    modport slave (
        input  lit_valid, lit_var, lit_neg, lit_eoc, lit_eof,
        output lit_ready
    );
endinterface

// File: rtl/sat_formula_sequencer.sv
// Streams CNF literals onto the SAT array command bus, inserts commit/clear steps
// and captures the array result. Macro SAT_SEQ_CLAUSE_CNT_EN enables clause_cnt.
module sat_formula_sequencer #(
    parameter int VAR_W   = 5,
    parameter int RES_LAT = 3
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   start,
    input  logic                   abort,
    sat_formula_sequencer_if.slave lit,
    output logic [1:0]             stateVal,
    output logic [VAR_W-1:0]       varPos,
    output logic                   negCtrl,
    input  logic                   satRes,
    output logic                   busy,
    output logic                   done,
    output logic                   sat,
    output logic [15:0]            clause_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CLR_ALL,
        LOAD,
        COMMIT,
        CLR_CL,
        WAIT_RES,
        ABORT_CLR
    } state_t;

    localparam logic [1:0] CMD_RESET  = 2'b00;
    localparam logic [1:0] CMD_EVAL   = 2'b01;
    localparam logic [1:0] CMD_COMMIT = 2'b10;
    localparam logic [1:0] CMD_HOLD   = 2'b11;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       last_clause;
    logic       handshake;

    assign handshake = lit.lit_valid & lit.lit_ready;

    // Commands are registered off each transition, so the CLR_ALL clear appears
    // in the first LOAD cycle and a literal can be accepted alongside it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            stateVal      <= CMD_RESET;
            varPos        <= '0;
            negCtrl       <= 1'b0;
            lit.lit_ready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            sat           <= 1'b0;
            wait_cnt      <= 4'd0;
            last_clause   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE && state != ABORT_CLR) begin
                state         <= ABORT_CLR;
                stateVal      <= CMD_RESET;
                lit.lit_ready <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        stateVal <= CMD_HOLD;
                        if (start) begin
                            state <= CLR_ALL;
                            busy  <= 1'b1;
                        end
                    end
                    CLR_ALL: begin
                        stateVal      <= CMD_RESET;
                        state         <= LOAD;
                        lit.lit_ready <= 1'b1;
                    end
                    LOAD: begin
                        if (handshake) begin
                            stateVal <= CMD_EVAL;
                            varPos   <= lit.lit_var;
                            negCtrl  <= lit.lit_neg;
                            if (lit.lit_eoc) begin
                                state         <= COMMIT;
                                lit.lit_ready <= 1'b0;
                                last_clause   <= lit.lit_eof;
                            end
                        end else begin
                            stateVal <= CMD_HOLD;
                        end
                    end
                    COMMIT: begin
                        stateVal <= CMD_COMMIT;
                        wait_cnt <= 4'(RES_LAT - 1);
                        state    <= last_clause ? WAIT_RES : CLR_CL;
                    end
                    CLR_CL: begin
                        stateVal      <= CMD_HOLD;
                        state         <= LOAD;
                        lit.lit_ready <= 1'b1;
                    end
                    WAIT_RES: begin
                        stateVal <= CMD_HOLD;
                        if (wait_cnt == 4'd0) begin
                            sat   <= satRes;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                    end
                    ABORT_CLR: begin
                        stateVal <= CMD_HOLD;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                    default: begin
                        stateVal      <= CMD_RESET;
                        lit.lit_ready <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SAT_SEQ_CLAUSE_CNT_EN
    // Counts completed commits only; an abort in COMMIT suppresses the count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clause_cnt <= 16'd0;
        end else if (state == CLR_ALL) begin
            clause_cnt <= 16'd0;
        end else if (state == COMMIT && !abort && clause_cnt != 16'hFFFF) begin
            clause_cnt <= clause_cnt + 16'd1;
        end
    end
`else
    assign clause_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_sat_formula_sequencer.sv
// Self-checking bench for sat_formula_sequencer: per-cycle vector tables built
// from a clause-level reference model, applied and compared in a loop.
module tb_sat_formula_sequencer;
    localparam int VAR_W   = 5;
    localparam int RES_LAT = 3;

    logic             clk    = 1'b0;
    logic             resetN = 1'b0;
    logic             start  = 1'b0;
    logic             abort  = 1'b0;
    logic             satRes = 1'b0;
    logic [1:0]       stateVal;
    logic [VAR_W-1:0] varPos;
    logic             negCtrl;
    logic             busy;
    logic             done;
    logic             sat;
    logic [15:0]      clause_cnt;

    sat_formula_sequencer_if #(.VAR_W(VAR_W)) lit_if ();

    sat_formula_sequencer #(.VAR_W(VAR_W), .RES_LAT(RES_LAT)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .start      (start),
        .abort      (abort),
        .lit        (lit_if),
        .stateVal   (stateVal),
        .varPos     (varPos),
        .negCtrl    (negCtrl),
        .satRes     (satRes),
        .busy       (busy),
        .done       (done),
        .sat        (sat),
        .clause_cnt (clause_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             start;
        logic             abort;
        logic             valid;
        logic [VAR_W-1:0] v;
        logic             neg;
        logic             eoc;
        logic             eof;
        logic             sres;
        logic [1:0]       e_cmd;
        logic [VAR_W-1:0] e_var;
        logic             e_neg;
        logic             e_ready;
        logic             e_busy;
        logic             e_done;
        logic             e_sat;
        logic             chk_cnt;
        logic [15:0]      e_cnt;
    } vec_t;

    typedef struct {
        logic [VAR_W-1:0] v;
        logic             neg;
        logic             eoc;
        int               stall;
        logic             eof_noise;
    } lit_t;

    vec_t vq[$];
    lit_t fq[$];

    logic [VAR_W-1:0] m_var = '0;
    logic             m_neg = 1'b0;
    logic             m_sat = 1'b0;
    int               n_vec = 0;
    int               n_bad = 0;

    function automatic vec_t mkVec(input logic [1:0] cmd, input logic rdy, input logic bsy);
        vec_t v;
        v.start   = 1'b0;
        v.abort   = 1'b0;
        v.valid   = rdy ? 1'b0 : 1'($urandom);
        v.v       = 5'($urandom);
        v.neg     = 1'($urandom);
        v.eoc     = 1'($urandom);
        v.eof     = 1'($urandom);
        v.sres    = 1'($urandom);
        v.e_cmd   = cmd;
        v.e_var   = m_var;
        v.e_neg   = m_neg;
        v.e_ready = rdy;
        v.e_busy  = bsy;
        v.e_done  = 1'b0;
        v.e_sat   = m_sat;
        v.chk_cnt = 1'b0;
        v.e_cnt   = 16'd0;
        return v;
    endfunction

    function automatic void addLit(input int var_idx, input logic neg, input logic eoc,
                                   input int stall, input logic eof_noise);
        lit_t l;
        l.v         = 5'(var_idx);
        l.neg       = neg;
        l.eoc       = eoc;
        l.stall     = stall;
        l.eof_noise = eof_noise;
        fq.push_back(l);
    endfunction

    // Expands the clause list in fq into the expected per-cycle command trace.
    function automatic void buildRun(input logic r, input bit noise, input bit abort_wait,
                                     input bit start_abort);
        vec_t       v;
        logic [1:0] show = 2'b00;
        int         nclause = 0;
        int         last_eoc = -1;
        foreach (fq[i]) if (fq[i].eoc) last_eoc = i;

        v = mkVec(2'b11, 1'b0, 1'b0);
        vq.push_back(v);
        v = mkVec(2'b11, 1'b0, 1'b0);
        v.start = 1'b1;
        v.abort = start_abort;
        vq.push_back(v);
        v = mkVec(2'b11, 1'b0, 1'b1);
        if (noise) v.start = 1'($urandom);
        vq.push_back(v);

        foreach (fq[i]) begin
            for (int s = 0; s < fq[i].stall; s++) begin
                v = mkVec(show, 1'b1, 1'b1);
                if (noise) v.start = 1'($urandom);
                vq.push_back(v);
                show = 2'b11;
            end
            v = mkVec(show, 1'b1, 1'b1);
            v.valid = 1'b1;
            v.v     = fq[i].v;
            v.neg   = fq[i].neg;
            v.eoc   = fq[i].eoc;
            v.eof   = (i == last_eoc) ? 1'b1 : (fq[i].eoc ? 1'b0 : fq[i].eof_noise);
            if (noise) v.start = 1'($urandom);
            vq.push_back(v);
            show  = 2'b01;
            m_var = fq[i].v;
            m_neg = fq[i].neg;
            if (fq[i].eoc) begin
                nclause++;
                v = mkVec(show, 1'b0, 1'b1);
                if (noise) v.start = 1'($urandom);
                vq.push_back(v);
                show = 2'b10;
                if (i != last_eoc) begin
                    v = mkVec(show, 1'b0, 1'b1);
                    vq.push_back(v);
                    show = 2'b11;
                end
            end
        end

        for (int w = 0; w < RES_LAT; w++) begin
            v = mkVec(show, 1'b0, 1'b1);
            v.sres = r;
            if (noise) v.start = 1'($urandom);
            if (abort_wait && w == 1) v.abort = 1'b1;
            vq.push_back(v);
            show = 2'b11;
            if (abort_wait && w == 1) break;
        end

        if (abort_wait) begin
            v = mkVec(2'b00, 1'b0, 1'b1);
            v.sres = r;
            vq.push_back(v);
            v = mkVec(2'b11, 1'b0, 1'b0);
            v.sres = r;
            vq.push_back(v);
        end else begin
            m_sat = r;
            v = mkVec(2'b11, 1'b0, 1'b0);
            v.sres    = r;
            v.e_done  = 1'b1;
            v.chk_cnt = 1'b1;
`ifdef SAT_SEQ_CLAUSE_CNT_EN
            v.e_cnt   = 16'(nclause);
`else
            v.e_cnt   = 16'd0;
`endif
            vq.push_back(v);
        end
    endfunction

    task automatic applyStimulus(input vec_t v);
        start            = v.start;
        abort            = v.abort;
        satRes           = v.sres;
        lit_if.lit_valid = v.valid;
        lit_if.lit_var   = v.v;
        lit_if.lit_neg   = v.neg;
        lit_if.lit_eoc   = v.eoc;
        lit_if.lit_eof   = v.eof;
    endtask

    task automatic checkOutput(input vec_t v, input int idx, input string tag);
        n_vec++;
        if (stateVal !== v.e_cmd || varPos !== v.e_var || negCtrl !== v.e_neg ||
            lit_if.lit_ready !== v.e_ready || busy !== v.e_busy || done !== v.e_done ||
            sat !== v.e_sat || (v.chk_cnt && clause_cnt !== v.e_cnt)) begin
            n_bad++;
            $display("[TB] FAIL %s[%0d]: got cmd=%b var=%0d neg=%b rdy=%b busy=%b done=%b sat=%b cnt=%0d, expected cmd=%b var=%0d neg=%b rdy=%b busy=%b done=%b sat=%b cnt=%0d(chk=%b)",
                     tag, idx, stateVal, varPos, negCtrl, lit_if.lit_ready, busy, done, sat,
                     clause_cnt, v.e_cmd, v.e_var, v.e_neg, v.e_ready, v.e_busy, v.e_done,
                     v.e_sat, v.e_cnt, v.chk_cnt);
        end
    endtask

    task automatic applyVectors(input string tag, input int upto);
        for (int i = 0; i < upto; i++) begin
            @(negedge clk);
            checkOutput(vq[i], i, tag);
            applyStimulus(vq[i]);
        end
    endtask

    task automatic runFormula(input string tag, input logic r, input bit noise,
                              input bit abort_wait, input bit start_abort);
        vq.delete();
        buildRun(r, noise, abort_wait, start_abort);
        applyVectors(tag, vq.size());
        fq.delete();
    endtask

    task automatic checkReset(input string tag);
        vec_t rv;
        rv = mkVec(2'b00, 1'b0, 1'b0);
        rv.e_var   = '0;
        rv.e_neg   = 1'b0;
        rv.e_sat   = 1'b0;
        rv.chk_cnt = 1'b1;
        rv.e_cnt   = 16'd0;
        checkOutput(rv, 0, tag);
    endtask

    initial begin
        vec_t idle;
        idle = mkVec(2'b11, 1'b0, 1'b0);
        idle.valid = 1'b0;
        applyStimulus(idle);
        start = 1'b0;
        #12;
        checkReset("reset");
        @(negedge clk);
        resetN = 1'b1;

        addLit(3, 1'b0, 1'b1, 0, 1'b0);
        runFormula("single_x3", 1'b1, 1'b0, 1'b0, 1'b0);

        addLit(1, 1'b0, 1'b0, 0, 1'b1);
        addLit(2, 1'b1, 1'b1, 0, 1'b0);
        addLit(4, 1'b0, 1'b1, 0, 1'b0);
        runFormula("two_clause", 1'b0, 1'b0, 1'b0, 1'b1);

        addLit(7, 1'b1, 1'b0, 0, 1'b0);
        addLit(9, 1'b0, 1'b0, 5, 1'b0);
        addLit(30, 1'b1, 1'b1, 0, 1'b0);
        runFormula("stall5", 1'b1, 1'b0, 1'b0, 1'b0);

        addLit(5, 1'b1, 1'b1, 1, 1'b0);
        addLit(6, 1'b0, 1'b1, 0, 1'b0);
        runFormula("abort_wait", 1'b0, 1'b0, 1'b1, 1'b0);

        for (int run = 0; run < 6; run++) begin
            int nc = $urandom_range(1, 4);
            for (int c = 0; c < nc; c++) begin
                int nl = $urandom_range(1, 3);
                for (int l = 0; l < nl; l++)
                    addLit($urandom_range(0, 31), 1'($urandom), l == nl - 1,
                           $urandom_range(0, 2), 1'($urandom));
            end
            runFormula("random", 1'($urandom), 1'b1, 1'b0, 1'b0);
        end

        addLit(12, 1'b1, 1'b1, 0, 1'b0);
        runFormula("pre_reset", 1'b1, 1'b0, 1'b0, 1'b0);

        vq.delete();
        addLit(10, 1'b0, 1'b0, 0, 1'b0);
        addLit(11, 1'b1, 1'b0, 0, 1'b0);
        addLit(13, 1'b0, 1'b1, 0, 1'b0);
        buildRun(1'b0, 1'b0, 1'b0, 1'b0);
        applyVectors("mid_load", 5);
        fq.delete();
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        checkReset("reset_mid_load");
        m_var = '0;
        m_neg = 1'b0;
        m_sat = 1'b0;
        applyStimulus(idle);
        @(negedge clk);
        resetN = 1'b1;

        addLit(3, 1'b0, 1'b1, 0, 1'b0);
        runFormula("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
